button_events: RTL and testbench
================================

Name: button_events

Overview:
- Parametrised successor to the 5-button debouncer: N independently debounced key inputs, press/release/auto-repeat event generation and a single serialised event port (one event per cycle, key code attached).
- Sits between the board push-buttons and the logger menu/control FSM, which consumes the one-cycle ticks and kcode.

Parameters:
- N_KEYS, 5, number of key inputs (2..16).
- KCODE_W, 3, kcode width; must satisfy 2^KCODE_W > N_KEYS.
- ACTIVE_LOW, 1, 1 means an input is pressed when at 0; 0 means pressed when at 1.
- DB_CYCLES, 1000, consecutive clocks a changed level must hold before it is accepted (20 us at 50 MHz); must be >= 2*N_KEYS.
- REPEAT_DELAY, 25000, clocks from a press event to the first repeat; 0 disables auto-repeat.
- REPEAT_RATE, 5000, clocks between subsequent repeats (>= 1).

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, asynchronous active-low reset.
- sw, input, N_KEYS, raw asynchronous key inputs.
- pos_tick, output, 1, one-cycle press event.
- neg_tick, output, 1, one-cycle release event.
- rpt_tick, output, 1, one-cycle auto-repeat event.
- kcode, output, KCODE_W, key of the last emitted event (index+1; 0 = none since reset).
- pressed, output, N_KEYS, debounced level per key (1 = pressed).

Behaviour:
- Reset (reset=0, async): synchronisers load the inactive raw level; pressed=0; counters=0; pending flags=0; pos/neg/rpt_tick=0; kcode=0; repeat engine idle.
- Sync: 2-flop synchroniser per key, then polarity normalised to act_i (1 = pressed).
- Debounce per key: if act_i == pressed_i, cnt_i=0. Otherwise cnt_i increments. When cnt_i reaches DB_CYCLES-1, pressed_i toggles and cnt_i=0. A glitch shorter than DB_CYCLES never changes pressed_i.
- pressed_i 0->1 sets pend_press_i. pressed_i 1->0 sets pend_rel_i. Both flags may be set at once.
- Arbiter (registered outputs, at most one tick per cycle):
  1. Select the lowest index i with pend_press_i | pend_rel_i.
  2. If pend_press_i: pos_tick=1, kcode=i+1, clear pend_press_i. Else: neg_tick=1, kcode=i+1, clear pend_rel_i.
  3. With no pending flags, a repeat expiry emits rpt_tick=1, kcode=rkey+1.
  4. With nothing to emit, all ticks=0 and kcode holds.
- Latency: an isolated clean edge gives its tick exactly 2 (sync) + DB_CYCLES + 1 clocks after the sw edge. Simultaneous edges on k keys are emitted on k consecutive cycles, lowest index first.
- Repeat engine, states IDLE/DELAY/RATE:
  - A pos_tick for key i loads rkey=i and rcnt=REPEAT_DELAY-1, enters DELAY. A later press of another key retargets the engine.
  - DELAY/RATE: rcnt decrements each clock while pressed_rkey=1.
  - At rcnt=0, raise a repeat request, reload rcnt=REPEAT_RATE-1, enter RATE.
  - A request blocked by pending events waits; it is emitted at the first free cycle, not dropped, and the counter keeps running.
  - pressed_rkey falling returns the engine to IDLE and discards any waiting request.
  - REPEAT_DELAY=0: engine stays IDLE permanently.
- Key held through reset release: no tick until DB_CYCLES after synchronisation, then a normal pos_tick.
- Reset mid-debounce or mid-repeat: everything is cleared. No release tick is produced for keys that were pressed.

Test Plan:
- Clean press: sw[0]=0 for 45 us, then 1 (DB_CYCLES=1000, REPEAT_DELAY=0) -> one pos_tick with kcode=1 at 20.06 us after the edge, pressed[0] high, then one neg_tick with kcode=1 after release; no other ticks.
- Glitches: sw[1] toggles every 500 ns for 2 us around press and release edges -> exactly one pos_tick and one neg_tick, both with kcode=2; no extra ticks.
- Simultaneous press: sw[4:2] fall on the same clock -> pos_tick on 3 consecutive cycles with kcode 3, 4, 5 in that order.
- Auto-repeat: REPEAT_DELAY=100, REPEAT_RATE=50, hold sw[3] for 400 clocks after debounce -> pos_tick (kcode=4), rpt_tick at +100, +150, +200 … clocks, neg_tick on release, then no further rpt_tick.
- Repeat blocked: a repeat expiry coincides with a pending press of key 0 -> pos_tick kcode=1 first, then rpt_tick on the next cycle.
- Async reset mid-press: assert reset while pressed[2]=1 -> all outputs 0 immediately, no neg_tick. sw[2] still low at release -> pos_tick kcode=3 after DB_CYCLES+3 clocks.

Source files
------------

// File: rtl/button_events.sv
// Debounced N-key front end: press/release/auto-repeat events serialised onto one
// tick port with the originating key code attached.
module button_events #(
  parameter int N_KEYS       = 5,
  parameter int KCODE_W      = 3,
  parameter int ACTIVE_LOW   = 1,
  parameter int DB_CYCLES    = 1000,
  parameter int REPEAT_DELAY = 25000,
  parameter int REPEAT_RATE  = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_KEYS-1:0]  sw,
  output logic               pos_tick,
  output logic               neg_tick,
  output logic               rpt_tick,
  output logic [KCODE_W-1:0] kcode,
  output logic [N_KEYS-1:0]  pressed
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam int IDX_W = $clog2(N_KEYS);
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W  = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [N_KEYS-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [RC_W-1:0]   RC_DELAY = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]   RC_RATE  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RPT_IDLE = 2'd0, RPT_DELAY = 2'd1, RPT_RATE = 2'd2} rpt_state_t;

  logic [N_KEYS-1:0]             sync1_r, sync2_r, act_s;
  logic [N_KEYS-1:0]             pressed_r, toggle_s, rise_s, fall_s;
  logic [N_KEYS-1:0][CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [N_KEYS-1:0]             pend_press_r, pend_rel_r, pend_any_s, clr_press_s, clr_rel_s;
  logic [IDX_W-1:0]              sel_idx_s;
  logic                          sel_vld_s;
  logic                          pos_r, neg_r, rpt_r, pos_next_s, neg_next_s, rpt_next_s;
  logic [KCODE_W-1:0]            kcode_r, kcode_next_s;
  rpt_state_t                    rstate_r, rstate_next_s;
  logic [IDX_W-1:0]              rkey_r, rkey_next_s;
  logic [RC_W-1:0]               rcnt_r, rcnt_next_s;
  logic                          rwait_r, rwait_next_s, rkey_held_s, rexpire_s, rreq_s;

  // Two-flop synchroniser; reset loads the released level so no phantom edge appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
    end
  end

  assign act_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

  // Per-key debounce counters: a level must differ for DB_CYCLES clocks to be accepted.
  always_comb begin
    cnt_next_s = cnt_r;
    toggle_s   = {N_KEYS{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      if (act_s[i] == pressed_r[i]) begin
        cnt_next_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        cnt_next_s[i] = {CNT_W{1'b0}};
        toggle_s[i]   = 1'b1;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  assign rise_s     = toggle_s & ~pressed_r;
  assign fall_s     = toggle_s & pressed_r;
  assign pend_any_s = pend_press_r | pend_rel_r;
  assign sel_vld_s  = |pend_any_s;

  // Lowest pending index wins; scanning downwards leaves the smallest one selected.
  always_comb begin
    sel_idx_s = {IDX_W{1'b0}};
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      sel_idx_s = pend_any_s[i] ? IDX_W'(i) : sel_idx_s;
    end
  end

  assign rkey_held_s = pressed_r[rkey_r];
  assign rexpire_s   = (rstate_r != RPT_IDLE) && rkey_held_s && (rcnt_r == {RC_W{1'b0}});
  assign rreq_s      = rexpire_s || rwait_r;

  // Event arbiter: key events first, then a (possibly deferred) repeat request.
  always_comb begin
    pos_next_s   = 1'b0;
    neg_next_s   = 1'b0;
    rpt_next_s   = 1'b0;
    kcode_next_s = kcode_r;
    clr_press_s  = {N_KEYS{1'b0}};
    clr_rel_s    = {N_KEYS{1'b0}};
    if (sel_vld_s) begin
      kcode_next_s = KCODE_W'(sel_idx_s) + KCODE_W'(1);
      if (pend_press_r[sel_idx_s]) begin
        pos_next_s             = 1'b1;
        clr_press_s[sel_idx_s] = 1'b1;
      end else begin
        neg_next_s           = 1'b1;
        clr_rel_s[sel_idx_s] = 1'b1;
      end
    end else if (rreq_s) begin
      rpt_next_s   = 1'b1;
      kcode_next_s = KCODE_W'(rkey_r) + KCODE_W'(1);
    end else begin
      kcode_next_s = kcode_r;
    end
  end

  // Repeat engine: a press (re)targets it; a request that cannot be emitted is held.
  always_comb begin
    rstate_next_s = rstate_r;
    rkey_next_s   = rkey_r;
    rcnt_next_s   = rcnt_r;
    rwait_next_s  = rwait_r;
    if (pos_next_s && (REPEAT_DELAY != 0)) begin
      rstate_next_s = RPT_DELAY;
      rkey_next_s   = sel_idx_s;
      rcnt_next_s   = RC_DELAY;
      rwait_next_s  = rreq_s;
    end else begin
      case (rstate_r)
        RPT_DELAY, RPT_RATE: begin
          if (!rkey_held_s) begin
            rstate_next_s = RPT_IDLE;
            rwait_next_s  = 1'b0;
          end else if (rcnt_r == {RC_W{1'b0}}) begin
            rstate_next_s = RPT_RATE;
            rcnt_next_s   = RC_RATE;
            rwait_next_s  = rreq_s && !rpt_next_s;
          end else begin
            rcnt_next_s  = rcnt_r - RC_W'(1);
            rwait_next_s = rreq_s && !rpt_next_s;
          end
        end
        RPT_IDLE: begin
          rwait_next_s = 1'b0;
        end
        default: begin
          rstate_next_s = RPT_IDLE;
          rwait_next_s  = 1'b0;
        end
      endcase
    end
  end

  // Debounced levels, counters and pending-event flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed_r    <= {N_KEYS{1'b0}};
      cnt_r        <= '0;
      pend_press_r <= {N_KEYS{1'b0}};
      pend_rel_r   <= {N_KEYS{1'b0}};
    end else begin
      pressed_r    <= pressed_r ^ toggle_s;
      cnt_r        <= cnt_next_s;
      pend_press_r <= (pend_press_r & ~clr_press_s) | rise_s;
      pend_rel_r   <= (pend_rel_r & ~clr_rel_s) | fall_s;
    end
  end

  // Registered event outputs and repeat-engine state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_r    <= 1'b0;
      neg_r    <= 1'b0;
      rpt_r    <= 1'b0;
      kcode_r  <= {KCODE_W{1'b0}};
      rstate_r <= RPT_IDLE;
      rkey_r   <= {IDX_W{1'b0}};
      rcnt_r   <= {RC_W{1'b0}};
      rwait_r  <= 1'b0;
    end else begin
      pos_r    <= pos_next_s;
      neg_r    <= neg_next_s;
      rpt_r    <= rpt_next_s;
      kcode_r  <= kcode_next_s;
      rstate_r <= rstate_next_s;
      rkey_r   <= rkey_next_s;
      rcnt_r   <= rcnt_next_s;
      rwait_r  <= rwait_next_s;
    end
  end

  assign pos_tick = pos_r;
  assign neg_tick = neg_r;
  assign rpt_tick = rpt_r;
  assign kcode    = kcode_r;
  assign pressed  = pressed_r;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: events are logged with their cycle stamp and
// compared against hand-computed (type, kcode, cycle) lists.
module tb_button_events;
  localparam int DB  = 20;
  localparam int RD  = 100;
  localparam int RR  = 50;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] sw = 5'b11111;
  logic       pos_tick, neg_tick, rpt_tick;
  logic [2:0] kcode;
  logic [4:0] pressed;

  int cyc = 0;
  int n_checks = 0;
  int n_errs = 0;
  int multi = 0;
  int t0, t1, p;

  typedef struct {int c; int ty; int k;} ev_t;
  ev_t ev_q[$];

  button_events #(
    .N_KEYS(5), .KCODE_W(3), .ACTIVE_LOW(1),
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .pos_tick(pos_tick), .neg_tick(neg_tick), .rpt_tick(rpt_tick),
    .kcode(kcode), .pressed(pressed)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logger: 1 = press, 2 = release, 3 = repeat
  always @(negedge clk) begin
    if (reset) begin
      if (int'(pos_tick) + int'(neg_tick) + int'(rpt_tick) > 1) multi++;
      if (pos_tick) ev_q.push_back('{cyc, 1, int'(kcode)});
      if (neg_tick) ev_q.push_back('{cyc, 2, int'(kcode)});
      if (rpt_tick) ev_q.push_back('{cyc, 3, int'(kcode)});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input int ty, input int k, input int c);
    chk({tag, "_present"}, 32'(idx < ev_q.size()), 32'd1);
    if (idx < ev_q.size()) begin
      chk({tag, "_type"}, ev_q[idx].ty, ty);
      if (k >= 0) chk({tag, "_kcode"}, ev_q[idx].k, k);
      chk({tag, "_cycle"}, ev_q[idx].c, c);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clks(3);
    chk("rst_pressed", pressed, 0);
    chk("rst_ticks", {pos_tick, neg_tick, rpt_tick}, 0);
    chk("rst_kcode", kcode, 0);
    reset = 1'b1;
    clks(5);
    ev_q.delete();

    // Clean press and release of key 0
    t0 = cyc; sw[0] = 1'b0; clks(60);
    chk("t1_pressed", pressed, 5'b00001);
    t1 = cyc; sw[0] = 1'b1; clks(60);
    chk("t1_count", ev_q.size(), 2);
    chk_ev("t1_pos", 0, 1, 1, t0 + LAT);
    chk_ev("t1_neg", 1, 2, 1, t1 + LAT);
    chk("t1_released", pressed, 0);
    ev_q.delete();

    // Glitchy press and release of key 1 (5-clock bursts, shorter than DB)
    for (int i = 0; i < 4; i++) begin sw[1] = ~sw[1]; clks(5); end
    sw[1] = 1'b0; t0 = cyc; clks(60);
    for (int i = 0; i < 4; i++) begin sw[1] = ~sw[1]; clks(5); end
    sw[1] = 1'b1; t1 = cyc; clks(60);
    chk("t2_count", ev_q.size(), 2);
    chk_ev("t2_pos", 0, 1, 2, t0 + LAT);
    chk_ev("t2_neg", 1, 2, 2, t1 + LAT);
    ev_q.delete();

    // Simultaneous press/release of keys 2..4
    t0 = cyc; sw[4:2] = 3'b000; clks(50);
    t1 = cyc; sw[4:2] = 3'b111; clks(60);
    chk("t3_count", ev_q.size(), 6);
    for (int i = 0; i < 3; i++) begin
      chk_ev($sformatf("t3_pos%0d", i), i, 1, 3 + i, t0 + LAT + i);
      chk_ev($sformatf("t3_neg%0d", i), 3 + i, 2, 3 + i, t1 + LAT + i);
    end
    ev_q.delete();

    // Auto-repeat on key 3
    t0 = cyc; sw[3] = 1'b0; p = t0 + LAT; clks(403);
    t1 = cyc; sw[3] = 1'b1; clks(250);
    chk("t4_count", ev_q.size(), 9);
    chk_ev("t4_pos", 0, 1, 4, p);
    for (int j = 0; j < 7; j++)
      chk_ev($sformatf("t4_rpt%0d", j), 1 + j, 3, 4, p + RD + RR * j);
    chk_ev("t4_neg", 8, 2, 4, t1 + LAT);
    ev_q.delete();

    // Repeat expiry collides with a pending press of key 0
    t0 = cyc; sw[3] = 1'b0; clks(100);
    sw[0] = 1'b0; clks(50);
    sw[0] = 1'b1; sw[3] = 1'b1; clks(60);
    chk("t5_count", ev_q.size(), 5);
    chk_ev("t5_pos3", 0, 1, 4, t0 + LAT);
    chk_ev("t5_pos0", 1, 1, 1, t0 + LAT + RD);
    chk_ev("t5_rpt", 2, 3, -1, t0 + LAT + RD + 1);
    chk_ev("t5_neg0", 3, 2, 1, t0 + 150 + LAT);
    chk_ev("t5_neg3", 4, 2, 4, t0 + 151 + LAT);
    ev_q.delete();

    // Async reset while key 2 is held
    sw[2] = 1'b0; clks(40);
    chk("t6_pressed", pressed, 5'b00100);
    chk("t6_kcode_pre", kcode, 3);
    ev_q.delete();
    reset = 1'b0;
    #1;
    chk("t6_rst_pressed", pressed, 0);
    chk("t6_rst_ticks", {pos_tick, neg_tick, rpt_tick}, 0);
    chk("t6_rst_kcode", kcode, 0);
    clks(3);
    reset = 1'b1; t0 = cyc; clks(40);
    chk("t6_count", ev_q.size(), 1);
    chk_ev("t6_pos", 0, 1, 3, t0 + LAT);
    sw[2] = 1'b1; clks(60);
    chk("multi_tick", multi, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
